ext_mem_arbiter: RTL and testbench
==================================

Name: ext_mem_arbiter

Overview:
Round-robin arbiter that shares one native memory port (valid/addr/wdata/wstrb/rdata/ready) of ext_mem between N masters, e.g. the CPU data bus and the Versat databus. It sits in front of the ext_mem L1 cache port and grants one transaction at a time. An optional per-master lock keeps the grant across back-to-back transactions, bounded by a starvation limit.

Parameters:
N_MASTERS, 2, number of requesting masters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width; wstrb width is DATA_W/8
LOCK_MAX, 16, max consecutive locked transactions before forced release when others are waiting

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
m_valid  in  N_MASTERS  per-master request; held high until that master's m_ready
m_addr  in  N_MASTERS*ADDR_W  concatenated addresses, master 0 in LSBs
m_wdata  in  N_MASTERS*DATA_W  concatenated write data
m_wstrb  in  N_MASTERS*DATA_W/8  concatenated strobes; all-zero means read
m_lock  in  N_MASTERS  keep grant after the current transaction completes
m_rdata  out  DATA_W  read data, broadcast to all masters; valid only with m_ready
m_ready  out  N_MASTERS  one-cycle completion pulse to the granted master only
s_valid  out  1  request to ext_mem
s_addr  out  ADDR_W  muxed address
s_wdata  out  DATA_W  muxed write data
s_wstrb  out  DATA_W/8  muxed strobes
s_rdata  in  DATA_W  ext_mem read data
s_ready  in  1  ext_mem one-cycle completion pulse
gnt  out  N_MASTERS  registered one-hot grant; all-zero when idle
busy  out  1  high in BUSY state

Behaviour:
- Reset: state IDLE, gnt=0, busy=0, pointer=0, lock_cnt=0. All s_* outputs are 0 and m_ready=0, because they are gated by the grant. Reset mid-transaction abandons the transaction; no m_ready is issued.
- States: IDLE, BUSY.
- IDLE: if any m_valid is set, pick the first requester at or above pointer, wrapping modulo N_MASTERS. Register gnt one-hot and go to BUSY. Arbitration latency: request in cycle 0, s_valid high in cycle 1.
- BUSY outputs, combinational from gnt: s_valid=m_valid[g], s_addr/s_wdata/s_wstrb = slice g. m_ready[g]=s_ready; other m_ready bits are 0. m_rdata=s_rdata at all times.
- BUSY, s_ready=1, m_lock[g]=0: pointer<=(g+1) mod N, gnt<=0, lock_cnt<=0, go to IDLE. Minimum idle gap between grants is 1 cycle.
- BUSY, s_ready=1, m_lock[g]=1: lock_cnt<=lock_cnt+1. Force a release like the unlocked case if (lock_cnt+1)==LOCK_MAX and any other m_valid is high. Otherwise stay BUSY with the same g, with no gap.
- BUSY, s_ready=0, m_valid[g]=0, m_lock[g]=0: the locked master has abandoned its lock. Go to IDLE with pointer=(g+1) mod N.
- BUSY, s_ready=0, m_valid[g]=0, m_lock[g]=1: hold grant; s_valid=0.
- s_ready while IDLE is ignored (protocol violation); no m_ready is generated.
- lock_cnt saturates at LOCK_MAX and is $clog2(LOCK_MAX+1) bits wide. It resets whenever the grant changes.
- A lone requester with lock at LOCK_MAX is not released (no other waiter). It stays BUSY and lock_cnt stays saturated.
- Simultaneous requests in IDLE: pointer order decides; the others wait, with m_valid held.
- No combinational path from s_ready to s_valid. The only comb paths are the master-to-slave mux and s_ready/s_rdata to m_ready/m_rdata.

Decomposition:
- Shared package/header (alongside interconnect.vh): state encoding constants (ARB_IDLE=0, ARB_BUSY=1) and the native-bus field-width macros already used for REQ_W/RESP_W slicing.
- One sub-module is natural: rr_pick. It is combinational: inputs req[N] and pointer, output one-hot winner plus index; first set bit at or above pointer, wrapping. Everything else stays in ext_mem_arbiter.

Test Plan:
- Single master: m_valid[0]=1, addr=0x100, wstrb=0; s_ready on cycle 3 with s_rdata=0xDEADBEEF -> s_valid high in cycles 1-3, m_ready[0] pulses in cycle 3, m_rdata=0xDEADBEEF, gnt=01→00, pointer=1.
- Simultaneous: m_valid=11 after reset -> master 0 served first, then master 1 with a 1-cycle IDLE gap; m_ready[1] is never high during master 0's grant.
- Round-robin fairness: both masters continuously requesting, s_ready every 2nd cycle, 10 transactions -> grants alternate 0,1,0,1…, 5 each.
- Lock: m_lock[1]=1, m_valid=11, LOCK_MAX=4 -> master 1 completes 4 back-to-back transactions without a gap, then is forced off; master 0 is granted next.
- Lock abandon: master 0 locked; it drops m_valid and m_lock in the same cycle -> IDLE next cycle; pending master 1 granted the following cycle.
- Reset mid-op: assert rst while BUSY before s_ready -> next cycle gnt=0, busy=0, s_valid=0, no m_ready; the next request is arbitrated from pointer 0.

Source files
------------

// File: rtl/ext_mem_arbiter_pkg.sv
// Shared definitions for the ext_mem round-robin arbiter: FSM encoding,
// native-bus field widths and small index helpers.
package ext_mem_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Native bus request is {valid, addr, wdata, wstrb}; response is {rdata, ready}.
  function automatic int req_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int resp_w(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ext_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N. Returns the winner one-hot, its index and a hit flag.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [PW-1:0] idx,
  output logic          any
);

  int cand;

  always_comb begin
    win  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any && req[cand]) begin
        any       = 1'b1;
        win[cand] = 1'b1;
        idx       = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/ext_mem_arbiter.sv
// Round-robin arbiter sharing one ext_mem native port between N masters,
// with optional per-master grant locking bounded by LOCK_MAX.
module ext_mem_arbiter
  import ext_mem_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LOCK_MAX  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_MASTERS-1:0]            m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb,
  input  logic [N_MASTERS-1:0]            m_lock,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [N_MASTERS-1:0]            m_ready,
  output logic                            s_valid,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_wstrb,
  input  logic [DATA_W-1:0]               s_rdata,
  input  logic                            s_ready,
  output logic [N_MASTERS-1:0]            gnt,
  output logic                            busy
);

  localparam int SW = DATA_W / 8;
  localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW:0] LOCK_LIMIT = (CW + 1)'(LOCK_MAX);

  arb_state_e           state_q, state_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [PW-1:0]        gidx_q, gidx_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        lock_cnt_q, lock_cnt_d;

  logic [N_MASTERS-1:0] pick_win;
  logic [PW-1:0]        pick_idx;
  logic                 pick_any;

  logic                 g_valid, g_lock, others_waiting, lock_at_max, release_now;
  logic [CW:0]          lock_inc;

  rr_pick #(
    .N  (N_MASTERS),
    .PW (PW)
  ) u_rr_pick (
    .req (m_valid),
    .ptr (ptr_q),
    .win (pick_win),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The grant is one-hot or zero, so an OR of gated slices is the mux.
  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (gnt_q[i]) begin
        s_addr  = s_addr  | m_addr[i*ADDR_W +: ADDR_W];
        s_wdata = s_wdata | m_wdata[i*DATA_W +: DATA_W];
        s_wstrb = s_wstrb | m_wstrb[i*SW +: SW];
      end
    end
  end

  assign s_valid = |(m_valid & gnt_q);
  assign m_ready = gnt_q & {N_MASTERS{s_ready}};
  assign m_rdata = s_rdata;
  assign gnt     = gnt_q;
  assign busy    = (state_q == ARB_BUSY);

  assign g_valid        = |(m_valid & gnt_q);
  assign g_lock         = |(m_lock & gnt_q);
  assign others_waiting = |(m_valid & ~gnt_q);
  assign lock_inc       = {1'b0, lock_cnt_q} + 1'b1;
  // Compared with >= so a saturated lone owner still yields once someone else arrives.
  assign lock_at_max    = (lock_inc >= LOCK_LIMIT);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    lock_cnt_d  = lock_cnt_q;
    release_now = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d    = ARB_BUSY;
          gnt_d      = pick_win;
          gidx_d     = pick_idx;
          lock_cnt_d = '0;
        end
      end
      ARB_BUSY: begin
        if (s_ready) begin
          if (!g_lock || (lock_at_max && others_waiting)) begin
            release_now = 1'b1;
          end else begin
            lock_cnt_d = lock_at_max ? CW'(LOCK_MAX) : lock_inc[CW-1:0];
          end
        end else if (!g_valid && !g_lock) begin
          release_now = 1'b1;
        end
        if (release_now) begin
          state_d    = ARB_IDLE;
          gnt_d      = '0;
          ptr_d      = PW'(wrap_inc(int'(gidx_q), N_MASTERS));
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      gidx_q     <= '0;
      ptr_q      <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gidx_q     <= gidx_d;
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Self-checking bench for ext_mem_arbiter: directed vector table, hand
// sequences for multi-cycle corners, and random traffic against a model.
module tb_ext_mem_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int LM = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_valid;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_wdata;
  logic [NM*SW-1:0]  m_wstrb;
  logic [NM-1:0]     m_lock;
  logic [DW-1:0]     m_rdata;
  logic [NM-1:0]     m_ready;
  logic              s_valid;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [SW-1:0]     s_wstrb;
  logic [DW-1:0]     s_rdata;
  logic              s_ready;
  logic [NM-1:0]     gnt;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  ext_mem_arbiter #(
    .N_MASTERS (NM),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .LOCK_MAX  (LM)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_valid (m_valid),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_lock  (m_lock),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .s_valid (s_valid),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_wstrb (s_wstrb),
    .s_rdata (s_rdata),
    .s_ready (s_ready),
    .gnt     (gnt),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          restart;
    logic [NM-1:0] v;
    logic [NM-1:0] l;
    logic          sr;
    logic [DW-1:0] rd;
    logic [NM-1:0] e_gnt;
    logic          e_sv;
    logic [NM-1:0] e_mr;
    logic          e_busy;
  } vec_t;

  vec_t vecs[$];

  logic [AW-1:0] cur_addr  [NM];
  logic [DW-1:0] cur_wdata [NM];
  logic [SW-1:0] cur_wstrb [NM];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_payload();
    for (int i = 0; i < NM; i++) begin
      m_addr[i*AW +: AW]  = cur_addr[i];
      m_wdata[i*DW +: DW] = cur_wdata[i];
      m_wstrb[i*SW +: SW] = cur_wstrb[i];
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [NM-1:0] v, input logic [NM-1:0] l,
                               input logic sr, input logic [DW-1:0] rd);
    rst     = r;
    m_valid = v;
    m_lock  = l;
    s_ready = sr;
    s_rdata = rd;
    drive_payload();
  endtask

  // Expected slave-side payload follows from the expected grant alone.
  task automatic checkOutput(input string name, input logic [NM-1:0] e_gnt, input logic e_sv,
                             input logic [NM-1:0] e_mr, input logic e_busy, input logic [DW-1:0] e_rd);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [SW-1:0] es;
    ea = '0; ed = '0; es = '0;
    for (int i = 0; i < NM; i++) begin
      if (e_gnt[i]) begin
        ea = cur_addr[i]; ed = cur_wdata[i]; es = cur_wstrb[i];
      end
    end
    chk({name, ".gnt"},     64'(gnt),     64'(e_gnt));
    chk({name, ".s_valid"}, 64'(s_valid), 64'(e_sv));
    chk({name, ".m_ready"}, 64'(m_ready), 64'(e_mr));
    chk({name, ".busy"},    64'(busy),    64'(e_busy));
    chk({name, ".m_rdata"}, 64'(m_rdata), 64'(e_rd));
    chk({name, ".s_addr"},  64'(s_addr),  64'(ea));
    chk({name, ".s_wdata"}, 64'(s_wdata), 64'(ed));
    chk({name, ".s_wstrb"}, 64'(s_wstrb), 64'(es));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    applyStimulus(1'b1, '0, '0, 1'b0, '0);
    next_cycle();
    next_cycle();
  endtask

  // One full cycle: drive, sample mid-cycle, advance past the edge.
  task automatic step(input string name, input logic r, input logic [NM-1:0] v, input logic [NM-1:0] l,
                      input logic sr, input logic [DW-1:0] rd, input logic [NM-1:0] e_gnt,
                      input logic e_sv, input logic [NM-1:0] e_mr, input logic e_busy);
    applyStimulus(r, v, l, sr, rd);
    #3;
    checkOutput(name, e_gnt, e_sv, e_mr, e_busy, rd);
    next_cycle();
  endtask

  function automatic void add(input logic restart, input logic [NM-1:0] v, input logic [NM-1:0] l,
                              input logic sr, input logic [DW-1:0] rd, input logic [NM-1:0] e_gnt,
                              input logic e_sv, input logic [NM-1:0] e_mr, input logic e_busy);
    vec_t t;
    t.restart = restart; t.v = v; t.l = l; t.sr = sr; t.rd = rd;
    t.e_gnt = e_gnt; t.e_sv = e_sv; t.e_mr = e_mr; t.e_busy = e_busy;
    vecs.push_back(t);
  endfunction

  // Behavioural reference: owner index (-1 = nobody), round-robin pointer, lock run length.
  int mdl_owner, mdl_ptr, mdl_cnt;

  task automatic model_update(input logic r, input logic [NM-1:0] v, input logic [NM-1:0] l, input logic sr);
    bit others, rel;
    rel = 0;
    if (r) begin
      mdl_owner = -1; mdl_ptr = 0; mdl_cnt = 0;
    end else if (mdl_owner < 0) begin
      for (int k = 0; k < NM; k++) begin
        int c;
        c = (mdl_ptr + k) % NM;
        if (mdl_owner < 0 && v[c]) begin
          mdl_owner = c; mdl_cnt = 0;
        end
      end
    end else begin
      others = 0;
      for (int j = 0; j < NM; j++) if (j != mdl_owner && v[j]) others = 1;
      if (sr) begin
        if (!l[mdl_owner]) rel = 1;
        else if (mdl_cnt + 1 >= LM && others) rel = 1;
        else mdl_cnt = (mdl_cnt + 1 > LM) ? LM : mdl_cnt + 1;
      end else if (!v[mdl_owner] && !l[mdl_owner]) begin
        rel = 1;
      end
      if (rel) begin
        mdl_ptr = (mdl_owner + 1) % NM; mdl_owner = -1; mdl_cnt = 0;
      end
    end
  endtask

  initial begin
    logic [NM-1:0] pend, lk, e_gnt, e_mr, v_now;
    logic          sr, rv, e_sv;
    logic [DW-1:0] rd;
    int            cnt0, cnt1, txn;

    cur_addr[0]  = 32'h0000_0100; cur_addr[1]  = 32'h0000_0200;
    cur_wdata[0] = 32'h1111_1111; cur_wdata[1] = 32'h2222_2222;
    cur_wstrb[0] = 4'h0;          cur_wstrb[1] = 4'hF;

    // Single master read, pointer advance
    add(1, 2'b01, 2'b00, 0, 32'h0,         2'b00, 0, 2'b00, 0);
    add(0, 2'b01, 2'b00, 0, 32'h0,         2'b01, 1, 2'b00, 1);
    add(0, 2'b01, 2'b00, 0, 32'h0,         2'b01, 1, 2'b00, 1);
    add(0, 2'b01, 2'b00, 1, 32'hDEADBEEF,  2'b01, 1, 2'b01, 1);
    add(0, 2'b00, 2'b00, 0, 32'h0,         2'b00, 0, 2'b00, 0);
    add(0, 2'b11, 2'b00, 0, 32'h0,         2'b00, 0, 2'b00, 0);
    add(0, 2'b11, 2'b00, 0, 32'h5,         2'b10, 1, 2'b00, 1);
    // Simultaneous requests, and s_ready while idle
    add(1, 2'b11, 2'b00, 0, 32'h0,         2'b00, 0, 2'b00, 0);
    add(0, 2'b11, 2'b00, 0, 32'h0,         2'b01, 1, 2'b00, 1);
    add(0, 2'b11, 2'b00, 1, 32'hCAFE0001,  2'b01, 1, 2'b01, 1);
    add(0, 2'b10, 2'b00, 0, 32'h0,         2'b00, 0, 2'b00, 0);
    add(0, 2'b10, 2'b00, 0, 32'h0,         2'b10, 1, 2'b00, 1);
    add(0, 2'b10, 2'b00, 1, 32'hCAFE0002,  2'b10, 1, 2'b10, 1);
    add(0, 2'b00, 2'b00, 1, 32'hCAFE0003,  2'b00, 0, 2'b00, 0);
    add(0, 2'b00, 2'b00, 0, 32'h0,         2'b00, 0, 2'b00, 0);
    // Lock hold and abandon
    add(1, 2'b01, 2'b01, 0, 32'h0,         2'b00, 0, 2'b00, 0);
    add(0, 2'b01, 2'b01, 1, 32'h7,         2'b01, 1, 2'b01, 1);
    add(0, 2'b11, 2'b01, 0, 32'h0,         2'b01, 1, 2'b00, 1);
    add(0, 2'b10, 2'b01, 0, 32'h0,         2'b01, 0, 2'b00, 1);
    add(0, 2'b10, 2'b00, 0, 32'h0,         2'b01, 0, 2'b00, 1);
    add(0, 2'b10, 2'b00, 0, 32'h0,         2'b00, 0, 2'b00, 0);
    add(0, 2'b10, 2'b00, 0, 32'h0,         2'b10, 1, 2'b00, 1);
    add(0, 2'b10, 2'b00, 1, 32'h8,         2'b10, 1, 2'b10, 1);
    // LOCK_MAX forced release with another waiter
    add(1, 2'b10, 2'b10, 0, 32'h0,         2'b00, 0, 2'b00, 0);
    for (int i = 0; i < LM; i++) add(0, 2'b11, 2'b10, 1, 32'h100 + DW'(i), 2'b10, 1, 2'b10, 1);
    add(0, 2'b11, 2'b10, 0, 32'h0,         2'b00, 0, 2'b00, 0);
    add(0, 2'b11, 2'b10, 0, 32'h0,         2'b01, 1, 2'b00, 1);
    add(0, 2'b11, 2'b10, 1, 32'h9,         2'b01, 1, 2'b01, 1);
    add(0, 2'b10, 2'b10, 0, 32'h0,         2'b00, 0, 2'b00, 0);
    // Lone locked requester past LOCK_MAX keeps the grant
    add(1, 2'b10, 2'b10, 0, 32'h0,         2'b00, 0, 2'b00, 0);
    for (int i = 0; i < LM + 2; i++) add(0, 2'b10, 2'b10, 1, 32'h200 + DW'(i), 2'b10, 1, 2'b10, 1);
    add(0, 2'b10, 2'b10, 0, 32'h0,         2'b10, 1, 2'b00, 1);

    applyStimulus(1'b1, '0, '0, 1'b0, '0);
    @(posedge clk);
    #1;
    do_reset();
    step("reset_state", 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, 1'b0);

    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].restart) do_reset();
      step($sformatf("vec%0d", k), 1'b0, vecs[k].v, vecs[k].l, vecs[k].sr, vecs[k].rd,
           vecs[k].e_gnt, vecs[k].e_sv, vecs[k].e_mr, vecs[k].e_busy);
    end

    // Round-robin fairness: both always requesting, s_ready every 2nd cycle
    do_reset();
    cnt0 = 0; cnt1 = 0; txn = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b0, 2'b11, 2'b00, c[0], 32'h300 + DW'(c));
      #3;
      if (c[0]) begin
        chk($sformatf("rr_txn%0d", txn), 64'(m_ready), (txn % 2 == 0) ? 64'h1 : 64'h2);
        txn++;
      end
      if (m_ready[0]) cnt0++;
      if (m_ready[1]) cnt1++;
      next_cycle();
    end
    chk("rr_count0", 64'(cnt0), 64'd5);
    chk("rr_count1", 64'(cnt1), 64'd5);

    // Reset in the middle of a transaction returns the pointer to 0
    do_reset();
    step("rst_a", 1'b0, 2'b01, 2'b00, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, 1'b0);
    step("rst_b", 1'b0, 2'b01, 2'b00, 1'b1, 32'h1, 2'b01, 1'b1, 2'b01, 1'b1);
    step("rst_c", 1'b0, 2'b10, 2'b00, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, 1'b0);
    step("rst_d", 1'b0, 2'b10, 2'b00, 1'b0, 32'h0, 2'b10, 1'b1, 2'b00, 1'b1);
    step("rst_e", 1'b1, 2'b11, 2'b00, 1'b0, 32'h0, 2'b10, 1'b1, 2'b00, 1'b1);
    step("rst_f", 1'b0, 2'b11, 2'b00, 1'b1, 32'h2, 2'b00, 1'b0, 2'b00, 1'b0);
    step("rst_g", 1'b0, 2'b11, 2'b00, 1'b0, 32'h0, 2'b01, 1'b1, 2'b00, 1'b1);

    // Random traffic against the reference model
    do_reset();
    mdl_owner = -1; mdl_ptr = 0; mdl_cnt = 0;
    pend = '0; lk = '0;
    for (int c = 0; c < 800; c++) begin
      rv = ($urandom_range(199) == 0);
      for (int i = 0; i < NM; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          cur_addr[i]  = $urandom;
          cur_wdata[i] = $urandom;
          cur_wstrb[i] = SW'($urandom);
        end
        if ($urandom_range(4) == 0) lk[i] = ~lk[i];
        if (pend[i] && $urandom_range(39) == 0) begin
          pend[i] = 1'b0;
          lk[i]   = 1'b0;
        end
      end
      sr = ($urandom_range(2) == 0);
      rd = $urandom;
      v_now = pend;
      e_gnt = '0; e_mr = '0; e_sv = 1'b0;
      if (mdl_owner >= 0) begin
        e_gnt[mdl_owner] = 1'b1;
        e_sv = v_now[mdl_owner];
        if (sr) e_mr[mdl_owner] = 1'b1;
      end
      applyStimulus(rv, v_now, lk, sr, rd);
      #3;
      checkOutput($sformatf("rand%0d", c), e_gnt, e_sv, e_mr, mdl_owner >= 0, rd);
      model_update(rv, v_now, lk, sr);
      pend = pend & ~e_mr;
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
